// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot-time ROM loader.
// Contents: FSM state encoding, frame sync byte, error codes, bus widths,
// and small helpers for word addressing and state classification.
package rom_loader_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN0 = 3'd2,
    ST_LEN1 = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } ldr_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } ldr_err_e;

  // Byte address of word 'idx' relative to 'base' (32-bit unsigned arithmetic).
  function automatic logic [INST_ADDR_BUS-1:0] word_addr(input logic [INST_ADDR_BUS-1:0] base,
                                                         input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

  // True while a frame is being received (SYNC through CSUM).
  function automatic logic in_frame(input ldr_state_e s);
    return (s inside {[ST_SYNC:ST_CSUM]});
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write port of the loader, bundled together.
// Ports: byte_vld/byte_dat/byte_rdy (UART RX side), wr_en/wr_addr/wr_dat (ROM side).
// master = loader view; slave = environment view (byte source + ROM).
interface rom_loader_if;
  import rom_loader_pkg::*;

  logic                     byte_vld;
  logic [7:0]               byte_dat;
  logic                     byte_rdy;
  logic                     wr_en;
  logic [INST_ADDR_BUS-1:0] wr_addr;
  logic [INST_DATA_BUS-1:0] wr_dat;

  modport master (
    input  byte_vld, byte_dat,
    output byte_rdy, wr_en, wr_addr, wr_dat
  );

  modport slave (
    output byte_vld, byte_dat,
    input  byte_rdy, wr_en, wr_addr, wr_dat
  );

endinterface

// File: rtl/rom_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words.
// Latency: word_vld_o/word_o one cycle after the 4th byte strobe.
// Backpressure: none; every strobed byte is consumed.
// Ports: clr_i resets the byte counter; byte_vld_i/byte_i strobe a byte in;
// last_o flags (combinationally) that the current byte completes a word.
module word_packer
  import rom_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     byte_vld_i,
  input  logic [7:0]               byte_i,
  output logic                     last_o,
  output logic                     word_vld_o,
  output logic [INST_DATA_BUS-1:0] word_o
);

  logic [1:0]               cnt_q, cnt_d;
  logic [23:0]              sh_q, sh_d;
  logic [INST_DATA_BUS-1:0] word_q, word_d;
  logic                     vld_q, vld_d;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    word_d = word_q;
    last_o = byte_vld_i && (cnt_q == 2'd3);
    vld_d  = last_o;
    if (clr_i) begin
      cnt_d = 2'd0;
      sh_d  = 24'd0;
    end else if (byte_vld_i) begin
      // Shift right so byte 0 of the word ends up in bits [7:0].
      sh_d  = {byte_i, sh_q[23:8]};
      cnt_d = cnt_q + 2'd1;
      if (last_o) begin
        word_d = {byte_i, sh_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      sh_q   <= 24'd0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_vld_o = vld_q;
  assign word_o     = word_q;

endmodule

// File: rtl/rom_loader.sv
// Boot loader: parses a framed byte stream, writes ROM words, checks checksum.
// Latency: one ROM write the cycle after each word's 4th byte; status the cycle after.
// Backpressure: byte_rdy high in SYNC..CSUM, one byte per cycle with no stall.
// Ports: clk/rst, start_i arm pulse, bus (byte stream in, ROM write out),
// cpu_hold_o, busy_o, done_o, err_o, err_code_o status to the system controller.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 4096,
  parameter int          TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  rom_loader_if.master      bus,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  localparam int          TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);

  ldr_state_e               state_q, state_d;
  ldr_err_e                 code_q, code_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     rdy_q, rdy_d;
  logic                     busy_q, busy_d;
  logic                     hold_q, hold_d;
  logic [7:0]               len_lo_q, len_lo_d;
  logic [15:0]              nwords_q, nwords_d;
  logic [31:0]              idx_q, idx_d;
  logic [7:0]               csum_q, csum_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [INST_ADDR_BUS-1:0] wr_addr_q, wr_addr_d;

  logic        accept;
  logic        pk_clr;
  logic        pk_last;
  logic [15:0] len_rx;

  assign accept = bus.byte_vld && rdy_q;
  assign len_rx = {bus.byte_dat, len_lo_q};

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pk_clr),
    .byte_vld_i (accept && (state_q == ST_DATA)),
    .byte_i     (bus.byte_dat),
    .last_o     (pk_last),
    .word_vld_o (bus.wr_en),
    .word_o     (bus.wr_dat)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    done_d    = done_q;
    err_d     = err_q;
    len_lo_d  = len_lo_q;
    nwords_d  = nwords_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    tmo_d     = tmo_q;
    wr_addr_d = wr_addr_q;
    pk_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_SYNC;
          code_d  = ERR_NONE;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = 32'd0;
          csum_d  = 8'd0;
          tmo_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (accept && (bus.byte_dat == LOADER_SYNC_BYTE)) begin
          state_d = ST_LEN0;
          tmo_d   = '0;
        end
      end
      ST_LEN0: begin
        if (accept) begin
          len_lo_d = bus.byte_dat;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          nwords_d = len_rx;
          if ((len_rx == 16'd0) || ({16'd0, len_rx} > MAX_W)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d = csum_q + bus.byte_dat;
          if (pk_last) begin
            wr_addr_d = word_addr(BASE_ADDR, idx_q);
            idx_d     = idx_q + 32'd1;
            if ((idx_q + 32'd1) == {16'd0, nwords_q}) begin
              state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (bus.byte_dat == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte timeout once the sync byte has been seen.
    if (state_q inside {[ST_LEN0:ST_CSUM]}) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // Status flags follow the next state so they change with it.
    rdy_d  = in_frame(state_d);
    busy_d = in_frame(state_d);
    hold_d = in_frame(state_d) || (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      code_q    <= ERR_NONE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= 1'b0;
      len_lo_q  <= 8'd0;
      nwords_q  <= 16'd0;
      idx_q     <= 32'd0;
      csum_q    <= 8'd0;
      tmo_q     <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      len_lo_q  <= len_lo_d;
      nwords_q  <= nwords_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      tmo_q     <= tmo_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.byte_rdy = rdy_q;
  assign bus.wr_addr  = wr_addr_q;
  assign cpu_hold_o   = hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: scoreboard of expected ROM writes
// (address, data, cycle) popped by a write monitor, plus status checks.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int TMO = 100;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       cpu_hold_o, busy_o, done_o, err_o;
  logic [1:0] err_code_o;

  rom_loader_if bus();

  rom_loader #(
    .BASE_ADDR   (32'h0000_0000),
    .MAX_WORDS   (4096),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .bus        (bus),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  exp_wr_t     exp_q[$];
  logic [31:0] words[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Write monitor: every wr_en cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.wr_en === 1'b1) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_data", bus.wr_dat, e.data);
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Presents a byte; returns at the negedge preceding the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.byte_vld = 1'b1;
    bus.byte_dat = b;
    while (bus.byte_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rdy_wait", {31'd0, bus.byte_rdy}, 32'd1);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.byte_vld = 1'b0;
    bus.byte_dat = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    check("rdy_before_start", {31'd0, bus.byte_rdy}, 32'd0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Sends sync, length, words[0..nw-1] and the checksum plus cs_delta,
  // pushing the expected ROM writes; returns one cycle after the checksum edge.
  task automatic send_frame(input int nw, input logic [7:0] cs_delta);
    logic [7:0]  cs;
    logic [31:0] w;
    exp_wr_t     e;
    cs = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(nw));
    send_byte(8'(nw >> 8));
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        cs = cs + w[8*k +: 8];
        if (k == 3) begin
          e.addr = 32'(i) * 32'd4;
          e.data = w;
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
    send_byte(cs + cs_delta);
    idle_bus();
  endtask

  task automatic check_ok(input string tag, input int wr_before, input int nw);
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check({tag, "_nwr"}, 32'(wr_cnt - wr_before), 32'(nw));
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    bus.byte_vld = 1'b0;
    bus.byte_dat = 8'h00;
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_006F;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_wr_addr", bus.wr_addr, 32'd0);
    check("rst_wr_data", bus.wr_dat, 32'd0);
    check("rst_status", {26'd0, cpu_hold_o, busy_o, done_o, err_o, err_code_o}, 32'd0);
    check("rst_rdy", {31'd0, bus.byte_rdy}, 32'd0);

    // Basic two-word frame
    wb = wr_cnt;
    pulse_start();
    check("sync_busy", {31'd0, busy_o}, 32'd1);
    check("sync_hold", {31'd0, cpu_hold_o}, 32'd1);
    send_frame(2, 8'h00);
    check_ok("basic", wb, 2);
    check("held_addr", bus.wr_addr, 32'h4);
    check("held_data", bus.wr_dat, 32'h6F);

    // Leading garbage discarded in SYNC
    wb = wr_cnt;
    pulse_start();
    check("restart_done_clr", {31'd0, done_o}, 32'd0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(2, 8'h00);
    check_ok("garbage", wb, 2);

    // Bad checksum: writes still happen, error code 2
    wb = wr_cnt;
    pulse_start();
    send_frame(2, 8'h01);
    check("csum_err", {31'd0, err_o}, 32'd1);
    check("csum_code", {30'd0, err_code_o}, 32'd2);
    check("csum_hold", {31'd0, cpu_hold_o}, 32'd1);
    check("csum_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    check("csum_nwr", 32'(wr_cnt - wb), 32'd2);

    // Zero length
    wb = wr_cnt;
    pulse_start();
    check("start_clr_err", {31'd0, err_o}, 32'd0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    idle_bus();
    check("len0_err", {31'd0, err_o}, 32'd1);
    check("len0_code", {30'd0, err_code_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("len0_nwr", 32'(wr_cnt - wb), 32'd0);

    // Length MAX_WORDS+1 = 4097
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    idle_bus();
    check("lenmax_err", {31'd0, err_o}, 32'd1);
    check("lenmax_code", {30'd0, err_code_o}, 32'd1);
    check("lenmax_busy", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    check("lenmax_nwr", 32'(wr_cnt - wb), 32'd0);

    // Random five-word frame
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    wb = wr_cnt;
    pulse_start();
    send_frame(5, 8'h00);
    check_ok("rand5", wb, 5);

    // Timeout after two data bytes
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_006F;
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00);
    idle_bus();
    repeat (TMO - 1) @(negedge clk);
    check("tmo_early", {31'd0, err_o}, 32'd0);
    @(negedge clk);
    check("tmo_err", {31'd0, err_o}, 32'd1);
    check("tmo_code", {30'd0, err_code_o}, 32'd3);
    check("tmo_hold", {31'd0, cpu_hold_o}, 32'd1);

    // Reset on the edge that would complete the first word
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    bus.byte_dat = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.byte_vld = 1'b0;
    check("mid_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("mid_rst_status", {26'd0, cpu_hold_o, busy_o, done_o, err_o, err_code_o}, 32'd0);
    check("mid_rst_addr", bus.wr_addr, 32'd0);
    check("mid_rst_data", bus.wr_dat, 32'd0);
    check("mid_rst_rdy", {31'd0, bus.byte_rdy}, 32'd0);
    wb = wr_cnt;
    repeat (2) @(negedge clk);
    check("mid_rst_nwr", 32'(wr_cnt - wb), 32'd0);

    // Recovery frame
    pulse_start();
    send_frame(2, 8'h00);
    check_ok("recover", wb, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader that writes the instruction ROM through its write port. Accepts a framed little-endian byte stream from the UART receiver, assembles 32-bit words, issues one ROM write per word at sequential word addresses, and verifies a trailing checksum. Holds the CPU core in reset while loading and reports done or error to the system controller.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written; word aligned.
- `MAX_WORDS`, 4096: largest accepted word count; equals ROM depth in words.
- `TIMEOUT_CYC`, 50_000_000: idle cycles between accepted bytes before the frame is aborted.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous reset, active-high.
- `start_i  in  1`: one-cycle pulse arming the loader; ignored unless in IDLE, DONE or ERR.
- `byte_vld_i  in  1`: received byte valid, from UART RX.
- `byte_i  in  8`: received byte.
- `byte_rdy_o  out  1`: byte accepted when `byte_vld_i & byte_rdy_o`.
- `wr_en_o  out  1`: ROM write enable, one-cycle pulse per word.
- `wr_addr_o  out  32`: ROM write byte address.
- `wr_data_o  out  32`: ROM write data.
- `cpu_hold_o  out  1`: holds the core in reset.
- `busy_o  out  1`: frame in progress.
- `done_o  out  1`: level; last frame loaded with a good checksum.
- `err_o  out  1`: level; last frame aborted.
- `err_code_o  out  2`: 1 = bad length, 2 = checksum mismatch, 3 = timeout.

## Operation
- Frame format: sync byte 8'hA5, word count N as 2 bytes (LSB first), 4·N data bytes (each word LSB first), 1 checksum byte equal to the sum mod 256 of all data bytes.
- States: IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + `start_i` → SYNC. Clear `done_o`, `err_o`, `err_code_o`, word index, byte counter and checksum accumulator.
- SYNC: bytes other than 8'hA5 are discarded and the state is unchanged. 8'hA5 → LEN0. No timeout in SYNC.
- LEN0: latch N[7:0] → LEN1. LEN1: latch N[15:8]. If N == 0 or N > MAX_WORDS → ERR with code 1; otherwise → DATA.
- DATA: shift bytes into the word; byte k of the word goes to bits [8k+7:8k]. Every data byte is added into the 8-bit accumulator. On the 4th byte, register the write: `wr_data_o` = word, `wr_addr_o` = BASE_ADDR + 4·index, then increment index. After word N → CSUM.
- CSUM: byte == accumulator → DONE; mismatch → ERR with code 2.
- Timeout: in LEN0..CSUM, TIMEOUT_CYC cycles with no accepted byte → ERR with code 3. The counter resets on each accepted byte.
- `byte_rdy_o` = 1 in SYNC..CSUM; 0 otherwise.
- `busy_o` = 1 in SYNC..CSUM.
- `cpu_hold_o` = 1 in SYNC..CSUM and in ERR; 0 in IDLE and DONE.
- ROM words already written before an error are not rolled back.

## Timing
- Reset values: state IDLE; all outputs 0; `wr_addr_o`/`wr_data_o` 32'h0.
- Write latency: `wr_en_o` is high for exactly one cycle, in the cycle after the 4th byte of a word is accepted. Address and data are stable in that cycle and held until the next write.
- Back-to-back bytes, one per cycle, are accepted with no stall. Minimum frame time is 4N+4 cycles from the first accept.
- State changes take effect the cycle after the accepting edge. `done_o`/`err_o` rise the cycle after the CSUM byte, or the cycle after the error is detected.
- `start_i` during SYNC..CSUM: ignored.
- `start_i` coinciding with `byte_vld_i` in IDLE: the byte is not accepted, because `byte_rdy_o` is still 0.
- Reset mid-frame: return to IDLE next cycle with all outputs 0; a pending write is dropped.
- Index/address arithmetic is 32-bit unsigned. With N ≤ MAX_WORDS, wrap-around is impossible.

## Structure
- Shared defines file gains: the state encoding, `LOADER_SYNC_BYTE` 8'hA5, and the error codes. Address and data widths reuse the existing `INST_ADDR_BUS`/`INST_DATA_BUS`.
- One natural sub-module, `word_packer`, containing the byte shift register, the 2-bit byte counter and the `word_vld` pulse. The FSM, counters, checksum and timeout live in `rom_loader`.

## Test plan
- Frame A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 82 → writes 32'h00000013 @0x0 and 32'h0000006F @0x4. `done_o`=1, `cpu_hold_o`=0, and exactly 2 `wr_en_o` pulses.
- Leading garbage 00 FF then the same frame → identical writes; garbage discarded.
- Same frame with checksum 83 → both writes occur; `err_o`=1, `err_code_o`=2, `cpu_hold_o` stays 1.
- Length bytes 00 00, and separately MAX_WORDS+1 → ERR code 1 and no `wr_en_o`.
- TIMEOUT_CYC=100, stream stops after 2 data bytes → ERR code 3 at the 100th idle cycle; `rst` mid-DATA → all outputs 0 next cycle; a new `start_i` then a full frame loads correctly.
